// File: rtl/panda_pulse_train_pkg.sv
// ---------------------------------------------------------------------------
// panda_pulse_train_pkg
// Shared types and defaults for the pulse-train generator and its helpers.
//   pt_state_t : train sequencer states (idle, pulse high phase, pulse low phase)
//   CW_DEF     : default width of configuration registers and internal counters
//   SW_DEF     : default width of the COUNT/MISSED status registers
// ---------------------------------------------------------------------------
package panda_pulse_train_pkg;

  localparam int CW_DEF = 32;
  localparam int SW_DEF = 32;

  typedef enum logic [1:0] {
    PT_IDLE = 2'd0,
    PT_HIGH = 2'd1,
    PT_LOW  = 2'd2
  } pt_state_t;

endpackage

// File: rtl/panda_rise_det.sv
// ---------------------------------------------------------------------------
// panda_rise_det
// Registered rising-edge detector with an enable gate, shared by the bit-bus
// blocks. The previous sample of sig_i is held in a flop; the rise output is
// combinational, so it is valid in the same cycle the new level appears.
// Ports:
//   clk_i  in  1  system clock
//   rst_i  in  1  synchronous active-high reset (clears the history flop)
//   clr_i  in  1  synchronous clear of the history flop (register strobe)
//   sig_i  in  1  monitored bit-bus signal
//   en_i   in  1  gate; rises seen while low are not reported
//   rise_o out 1  high for the cycle in which sig_i goes 0 -> 1 while enabled
// ---------------------------------------------------------------------------
module panda_rise_det
  import panda_pulse_train_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic sig_i,
  input  logic en_i,
  output logic rise_o
);

  logic sig_d;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      sig_d <= 1'b0;
    end else begin
      sig_d <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_d & en_i;

endmodule

// File: rtl/panda_pulse_train.sv
// ---------------------------------------------------------------------------
// panda_pulse_train
// Pulse-train generator: every accepted rising edge on inp_i launches NPULSES
// pulses, each WIDTH clocks high, one starting every STEP clocks. The train
// configuration is captured at the trigger, so register writes made while a
// train runs only affect the following train.
//
// Build option: define PANDA_PULSE_TRAIN_CONT_EN to accept NPULSES==0 as a
// continuous train (runs until enable_i low, FORCE_RST or rst_i). Without it,
// NPULSES==0 is an invalid configuration and raises CFG_ERR.
//
// Ports:
//   clk_i     in  1   system clock, single domain
//   rst_i     in  1   synchronous active-high reset
//   inp_i     in  1   trigger input; rising edge starts a train
//   enable_i  in  1   gate; low ignores edges and aborts a running train
//   out_o     out 1   pulse-train output
//   active_o  out 1   high while a train is in progress
//   NPULSES   in  CW  pulses per train
//   WIDTH     in  CW  high clocks per pulse
//   STEP      in  CW  pulse period in clocks (must exceed WIDTH)
//   FORCE_RST in  1   register strobe: abort train and clear status
//   COUNT     out SW  pulses started in the current/last train
//   MISSED    out SW  triggers dropped while busy (saturating)
//   CFG_ERR   out 1   sticky flag: trigger rejected for invalid config
// ---------------------------------------------------------------------------
module panda_pulse_train
  import panda_pulse_train_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inp_i,
  input  logic          enable_i,
  output logic          out_o,
  output logic          active_o,
  input  logic [CW-1:0] NPULSES,
  input  logic [CW-1:0] WIDTH,
  input  logic [CW-1:0] STEP,
  input  logic          FORCE_RST,
  output logic [SW-1:0] COUNT,
  output logic [SW-1:0] MISSED,
  output logic          CFG_ERR
);

  pt_state_t     state;
  pt_state_t     state_next;

  logic [CW-1:0] npulses_q;
  logic [CW-1:0] width_q;
  logic [CW-1:0] step_q;
  logic          cont_q;

  // hcnt counts clocks of the current high phase, pcnt clocks since the
  // current pulse began; both are 1 on a pulse's first high cycle so they
  // never exceed WIDTH / STEP and cannot overflow even at STEP = 2^CW-1.
  logic [CW-1:0] hcnt;
  logic [CW-1:0] pcnt;
  logic [CW-1:0] pulse_idx;

  logic          trig;
  logic          cont_req;
  logic          cfg_ok;
  logic          last_pulse;
  logic          start_train;
  logic          start_pulse;
  logic          miss;
  logic          cfg_bad;

  panda_rise_det u_rise_det (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (FORCE_RST),
    .sig_i  (inp_i),
    .en_i   (enable_i),
    .rise_o (trig)
  );

`ifdef PANDA_PULSE_TRAIN_CONT_EN
  assign cont_req = (NPULSES == '0);
`else
  assign cont_req = 1'b0;
`endif

  assign cfg_ok = (WIDTH != '0) && (STEP > WIDTH) && ((NPULSES != '0) || cont_req);

  // A continuous train never reaches its last pulse, so pulse_idx may wrap.
  assign last_pulse = !cont_q && (pulse_idx == npulses_q);

  // Next-state and output decode. The train ends straight out of the last
  // high phase, so no trailing low phase is emitted and the following IDLE
  // cycle can already accept a new trigger.
  always_comb begin
    state_next  = state;
    start_train = 1'b0;
    start_pulse = 1'b0;
    miss        = 1'b0;
    cfg_bad     = 1'b0;
    out_o       = 1'b0;
    active_o    = 1'b0;

    case (state)
      PT_IDLE: begin
        if (trig) begin
          if (cfg_ok) begin
            start_train = 1'b1;
            state_next  = PT_HIGH;
          end else begin
            cfg_bad = 1'b1;
          end
        end
      end

      PT_HIGH: begin
        out_o    = 1'b1;
        active_o = 1'b1;
        miss     = trig;
        if (!enable_i) begin
          state_next = PT_IDLE;
        end else if (hcnt == width_q) begin
          state_next = last_pulse ? PT_IDLE : PT_LOW;
        end
      end

      PT_LOW: begin
        active_o = 1'b1;
        miss     = trig;
        if (!enable_i) begin
          state_next = PT_IDLE;
        end else if (pcnt == step_q) begin
          start_pulse = 1'b1;
          state_next  = PT_HIGH;
        end
      end

      default: begin
        state_next = PT_IDLE;
      end
    endcase
  end

  // State register, captured configuration, phase counters and status.
  // FORCE_RST behaves like reset for everything it touches and therefore
  // wins over a trigger arriving in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || FORCE_RST) begin
      state     <= PT_IDLE;
      npulses_q <= '0;
      width_q   <= '0;
      step_q    <= '0;
      cont_q    <= 1'b0;
      hcnt      <= '0;
      pcnt      <= '0;
      pulse_idx <= '0;
      COUNT     <= '0;
      MISSED    <= '0;
      CFG_ERR   <= 1'b0;
    end else begin
      state <= state_next;

      if (start_train) begin
        npulses_q <= NPULSES;
        width_q   <= WIDTH;
        step_q    <= STEP;
        cont_q    <= cont_req;
        hcnt      <= CW'(1);
        pcnt      <= CW'(1);
        pulse_idx <= CW'(1);
        COUNT     <= SW'(1);
      end else if (start_pulse) begin
        hcnt      <= CW'(1);
        pcnt      <= CW'(1);
        pulse_idx <= pulse_idx + CW'(1);
        COUNT     <= COUNT + SW'(1);
      end else begin
        if (state == PT_HIGH) begin
          hcnt <= hcnt + CW'(1);
        end
        if (state != PT_IDLE) begin
          pcnt <= pcnt + CW'(1);
        end
      end

      if (miss && (MISSED != '1)) begin
        MISSED <= MISSED + SW'(1);
      end

      if (cfg_bad) begin
        CFG_ERR <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_panda_pulse_train.sv
// ---------------------------------------------------------------------------
// tb_panda_pulse_train
// Self-checking bench for panda_pulse_train (built with CW=8, SW=8 so that the
// maximum STEP and MISSED saturation are reachable). A cycle-indexed reference
// model describes each train by its trigger cycle and captured configuration
// and derives out/active/COUNT arithmetically from the cycle offset.
// ---------------------------------------------------------------------------
module tb_panda_pulse_train;

  localparam int CW = 8;
  localparam int SW = 8;
  localparam longint SAT = (64'd1 << SW) - 1;

`ifdef PANDA_PULSE_TRAIN_CONT_EN
  localparam bit CONT_OK = 1'b1;
`else
  localparam bit CONT_OK = 1'b0;
`endif

  logic          clock;
  logic          rst;
  logic          inp;
  logic          enable;
  logic          frc;
  logic [CW-1:0] npulses;
  logic [CW-1:0] width;
  logic [CW-1:0] step;
  logic          out;
  logic          active;
  logic [SW-1:0] count;
  logic [SW-1:0] missed;
  logic          cfgErr;

  // Stimulus state shared by the tasks
  logic          curEn;
  logic [CW-1:0] cfgNp;
  logic [CW-1:0] cfgW;
  logic [CW-1:0] cfgS;

  // Reference model state
  longint cyc;
  bit     mBusy;
  longint mT0;
  longint mN;
  longint mW;
  longint mS;
  bit     mCont;
  longint mCount;
  longint mMissed;
  bit     mCfgErr;
  bit     mPrev;

  int vectors;
  int errors;

  panda_pulse_train #(
    .CW(CW),
    .SW(SW)
  ) dut (
    .clk_i     (clock),
    .rst_i     (rst),
    .inp_i     (inp),
    .enable_i  (enable),
    .out_o     (out),
    .active_o  (active),
    .NPULSES   (npulses),
    .WIDTH     (width),
    .STEP      (step),
    .FORCE_RST (frc),
    .COUNT     (count),
    .MISSED    (missed),
    .CFG_ERR   (cfgErr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts and reports
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic modelClear();
    mBusy   = 1'b0;
    mCount  = 0;
    mMissed = 0;
    mCfgErr = 1'b0;
    mPrev   = 1'b0;
  endtask

  // Compare all outputs with what the model says holds during cycle cyc
  task automatic checkAll();
    bit     expOut;
    longint off;
    expOut = 1'b0;
    if (mBusy) begin
      off    = cyc - mT0 - 1;
      expOut = ((off % mS) < mW);
    end
    checkOutput("out", {31'd0, out}, {31'd0, expOut});
    checkOutput("active", {31'd0, active}, {31'd0, mBusy});
    checkOutput("count", 32'(count), 32'(mCount));
    checkOutput("missed", 32'(missed), 32'(mMissed));
    checkOutput("cfg_err", {31'd0, cfgErr}, {31'd0, mCfgErr});
  endtask

  // Advance the model over cycle cyc given that cycle's inputs
  task automatic modelStep(input bit inpV, input bit enV, input bit frcV, input bit rstV);
    bit     trig;
    bit     valid;
    longint endc;
    if (rstV || frcV) begin
      modelClear();
    end else begin
      trig = inpV && !mPrev && enV;
      if (mBusy) begin
        if (trig && mMissed != SAT) mMissed++;
        endc = mT0 + 1 + (mN - 1) * mS + mW;
        if (!enV) begin
          mBusy = 1'b0;
        end else if (!mCont && (cyc + 1 == endc)) begin
          mBusy = 1'b0;
        end else begin
          mCount = ((cyc - mT0) / mS + 1) % (SAT + 1);
        end
      end else if (trig) begin
        valid = (cfgW != 0) && (cfgS > cfgW) && ((cfgNp != 0) || CONT_OK);
        if (valid) begin
          mBusy  = 1'b1;
          mT0    = cyc;
          mN     = longint'(cfgNp);
          mW     = longint'(cfgW);
          mS     = longint'(cfgS);
          mCont  = (cfgNp == 0);
          mCount = 1;
        end else begin
          mCfgErr = 1'b1;
        end
      end
      mPrev = inpV;
    end
  endtask

  // One clock cycle: check, drive, model, advance to the next falling edge
  task automatic applyStimulus(input bit inpV, input bit frcV, input bit rstV);
    checkAll();
    inp     = inpV;
    frc     = frcV;
    rst     = rstV;
    enable  = curEn;
    npulses = cfgNp;
    width   = cfgW;
    step    = cfgS;
    modelStep(inpV, curEn, frcV, rstV);
    @(negedge clock);
    cyc++;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    cyc     = 0;
    curEn   = 1'b1;
    cfgNp   = 8'd3;
    cfgW    = 8'd2;
    cfgS    = 8'd5;
    rst     = 1'b1;
    inp     = 1'b0;
    frc     = 1'b0;
    enable  = 1'b1;
    npulses = cfgNp;
    width   = cfgW;
    step    = cfgS;
    modelClear();
    repeat (3) @(negedge clock);

    // Reset state, then a basic 3 x (2 high / 5 period) train
    idleCycles(3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(3);
    // Retrigger mid-train: must be counted as missed
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(8);
    checkOutput("basic_count_end", 32'(count), 32'd3);
    checkOutput("basic_idle_end", {31'd0, active}, 32'd0);
    checkOutput("retrig_missed", 32'(missed), 32'd1);
    // Trigger on the first IDLE cycle: back-to-back train
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(3);
    // Configuration change mid-train only affects the next train
    cfgS = 8'd8;
    idleCycles(14);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(30);

    // Invalid config: WIDTH == STEP
    cfgNp = 8'd3;
    cfgW  = 8'd4;
    cfgS  = 8'd4;
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(3);
    checkOutput("badcfg_err", {31'd0, cfgErr}, 32'd1);
    checkOutput("badcfg_out", {31'd0, out}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("force_clears_err", {31'd0, cfgErr}, 32'd0);
    idleCycles(2);

    // Abort after the 4th pulse of a 10-pulse train
    cfgNp = 8'd10;
    cfgW  = 8'd1;
    cfgS  = 8'd3;
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(10);
    curEn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("abort_active", {31'd0, active}, 32'd0);
    checkOutput("abort_out", {31'd0, out}, 32'd0);
    checkOutput("abort_count", 32'(count), 32'd4);
    curEn = 1'b1;
    idleCycles(3);

    // NPULSES == 0: continuous train or config error depending on build
    cfgNp = 8'd0;
    cfgW  = 8'd1;
    cfgS  = 8'd2;
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(12);
    applyStimulus(1'b0, 1'b1, 1'b0);
    idleCycles(3);

    // Maximum STEP with constant retriggering to saturate MISSED
    cfgNp = 8'd3;
    cfgW  = 8'd254;
    cfgS  = 8'd255;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 700; i++) applyStimulus(i[0], 1'b0, 1'b0);
    checkOutput("missed_saturated", 32'(missed), 32'(SAT));
    idleCycles(80);

    // Randomised episodes
    for (int ep = 0; ep < 40; ep++) begin
      cfgNp = 8'($urandom_range(0, 4));
      cfgW  = 8'($urandom_range(0, 4));
      cfgS  = 8'($urandom_range(0, 9));
      for (int i = 0; i < 80; i++) begin
        bit inpR;
        bit frcR;
        bit rstR;
        if ($urandom_range(0, 99) < 5) begin
          cfgNp = 8'($urandom_range(0, 4));
          cfgW  = 8'($urandom_range(0, 4));
          cfgS  = 8'($urandom_range(0, 9));
        end
        curEn = ($urandom_range(0, 99) >= 3);
        inpR  = ($urandom_range(0, 99) < 30);
        frcR  = ($urandom_range(0, 199) == 0);
        rstR  = ($urandom_range(0, 299) == 0);
        applyStimulus(inpR, frcR, rstR);
      end
    end
    curEn = 1'b1;
    idleCycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
